// File: rtl/branch_rs_scheduler_pkg.sv
// Shared types and ROB-age helpers for the branch reservation station.
package branch_rs_scheduler_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;
  localparam int PREG_W    = 7;

  localparam logic [TAG_W:0] ROB_SZ  = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [6:0]     OP_JALR = 7'b1100111;
  localparam logic [6:0]     OP_BR   = 7'b1100011;
  localparam logic [2:0]     F3_BNE  = 3'b001;

  typedef struct packed {
    logic [6:0]        Opcode;
    logic [2:0]        func3;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] prd;
    logic [TAG_W-1:0]  rob_index;
    logic [11:0]       imm;
  } rs_data;

  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
    logic [TAG_W:0] d;
    d = {1'b0, tag} + ROB_SZ - {1'b0, head};
    if (d >= ROB_SZ) d = d - ROB_SZ;
    return d[TAG_W-1:0];
  endfunction

  // Strictly younger than mtag and older than the allocation tail.
  function automatic logic in_squash_range(input logic [TAG_W-1:0] tag,
                                           input logic [TAG_W-1:0] mtag,
                                           input logic [TAG_W-1:0] tail);
    logic [TAG_W-1:0] d, t;
    d = rob_age(tag, mtag);
    t = rob_age(tail, mtag);
    return (d != '0) && (d < t);
  endfunction
endpackage

// File: rtl/branch_age_picker.sv
// Oldest-first select: one-hot grant of the ready entry with the smallest age.
module branch_age_picker
  import branch_rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][TAG_W-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        found
);
  logic [TAG_W-1:0] best;

  always_comb begin
    grant = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || age[i] < best)) begin
        found    = 1'b1;
        best     = age[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_rs_scheduler.sv
// Branch reservation station: wakeup, oldest-ready issue to fu_branch, mispredict squash.
module branch_rs_scheduler
  import branch_rs_scheduler_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              disp_valid,
  input  rs_data                            disp_data,
  input  logic                              disp_ps1_rdy,
  input  logic                              disp_ps2_rdy,
  output logic                              disp_ready,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]   wb_preg,
  input  logic [TAG_W-1:0]                  rob_head,
  input  logic [TAG_W-1:0]                  curr_rob_tag,
  input  logic                              mispredict,
  input  logic [TAG_W-1:0]                  mispredict_tag,
  input  logic                              fu_ready,
  output logic                              issued,
  output rs_data                            issue_data,
  output logic [$clog2(DEPTH):0]            occupancy
);
  logic [DEPTH-1:0]            valid, rdy1, rdy2;
  rs_data                      ent [DEPTH];
  logic [DEPTH-1:0]            ready, alloc, squash, wk1, wk2, grant;
  logic [DEPTH-1:0][TAG_W-1:0] age;
  logic                        has_free, found, disp_fire, issue_fire;
  logic                        d_rdy1, d_rdy2;

  // preg 0 is hardwired ready; otherwise any matching writeback strobe wakes it.
  function automatic logic woken(input logic [PREG_W-1:0]               p,
                                 input logic [WB_PORTS-1:0]             v,
                                 input logic [WB_PORTS-1:0][PREG_W-1:0] pr);
    logic hit;
    hit = (p == '0);
    for (int k = 0; k < WB_PORTS; k++)
      if (v[k] && pr[k] == p) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    alloc    = '0;
    has_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !has_free) begin
        alloc[i] = 1'b1;
        has_free = 1'b1;
      end
      ready[i]  = valid[i] & rdy1[i] & rdy2[i];
      age[i]    = rob_age(ent[i].rob_index, rob_head);
      squash[i] = valid[i] & in_squash_range(ent[i].rob_index, mispredict_tag, curr_rob_tag);
      wk1[i]    = woken(ent[i].ps1, wb_valid, wb_preg);
      wk2[i]    = woken(ent[i].ps2, wb_valid, wb_preg);
    end
  end

  branch_age_picker #(.DEPTH(DEPTH)) u_pick (
    .ready (ready),
    .age   (age),
    .grant (grant),
    .found (found)
  );

  assign disp_ready = has_free & ~mispredict;
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_fire = fu_ready & found & ~mispredict;
  assign issued     = issue_fire;
  assign d_rdy1     = disp_ps1_rdy | woken(disp_data.ps1, wb_valid, wb_preg);
  assign d_rdy2     = disp_ps2_rdy | (disp_data.Opcode == OP_JALR)
                    | woken(disp_data.ps2, wb_valid, wb_preg);

  always_comb begin
    issue_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (issue_fire && grant[i]) issue_data = ent[i];
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + {{$clog2(DEPTH){1'b0}}, valid[i]};
  end

  // Allocation uses the registered free map, so a slot vacated by issue
  // only becomes allocatable on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          if ((mispredict && squash[i]) || (issue_fire && grant[i])) valid[i] <= 1'b0;
          rdy1[i] <= rdy1[i] | wk1[i];
          rdy2[i] <= rdy2[i] | wk2[i];
        end else if (disp_fire && alloc[i]) begin
          valid[i] <= 1'b1;
          ent[i]   <= disp_data;
          rdy1[i]  <= d_rdy1;
          rdy2[i]  <= d_rdy2;
        end
      end
    end
  end
endmodule
